// File: rtl/sv_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// sv_uart_tx_arbiter
//
// Round-robin arbiter that shares the single transmit channel of
// sv_uart_engine among NUM_SRC AXI-stream requesters. Each grant is held for
// one word (or, with packet lock, one whole packet), optionally followed by a
// programmable idle gap. The output word sits in a single register tagged with
// the ID of the source that produced it.
//
// Optional feature macro: SV_UART_ARB_PKT_LOCK_EN
//   defined   : grant held until the word captured with tlast drains
//   undefined : tlast ignored, re-arbitration after every drained word
//
// Ports
//   iclk          clock
//   irst          synchronous active-high reset
//   s_axis_tdata  requester data, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   s_axis_tvalid per-source valid
//   s_axis_tlast  per-source end of packet
//   s_axis_tready per-source ready (at most one bit high)
//   m_axis_tdata  data to the engine
//   m_axis_tvalid valid to the engine
//   m_axis_tready engine ready
//   m_axis_tid    source of the word in the output register
//   igap          idle cycles inserted after each grant ends
//   ogrant        one-hot current grant (zero outside XFER)
//   obusy         high in every state except ARB
// -----------------------------------------------------------------------------
module sv_uart_tx_arbiter #(
  parameter int DATA_WIDTH = 24,
  parameter int NUM_SRC    = 4,
  parameter int ID_WIDTH   = $clog2(NUM_SRC)
) (
  input  logic                          iclk,
  input  logic                          irst,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  input  logic [15:0]                   igap,
  output logic [NUM_SRC-1:0]            ogrant,
  output logic                          obusy
);

  typedef enum logic [1:0] {ARB, XFER, GAP} state_t;

  state_t                state, state_n;
  logic [ID_WIDTH-1:0]   gidx, gidx_n;
  logic [ID_WIDTH-1:0]   last_grant;
  logic [ID_WIDTH-1:0]   sel_idx;
  logic [ID_WIDTH-1:0]   cand_id;
  logic                  sel_found;
  logic [15:0]           gap_cnt, gap_cnt_n;
  logic [NUM_SRC-1:0]    ogrant_n;
  logic                  cap, drn, grant_end;

  logic                  vld_p0;
  logic [DATA_WIDTH-1:0] data_p0;
  logic [ID_WIDTH-1:0]   tid_p0;

`ifdef SV_UART_ARB_PKT_LOCK_EN
  logic                  last_p0;
`else
  logic                  unused_tlast;
  assign unused_tlast = ^s_axis_tlast;
`endif

  // Search upward from last_grant+1, wrapping modulo NUM_SRC; the first
  // valid source found wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand_id   = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand_id = ID_WIDTH'((int'(last_grant) + k) % NUM_SRC);
      if (!sel_found && s_axis_tvalid[cand_id]) begin
        sel_found = 1'b1;
        sel_idx   = cand_id;
      end
    end
  end

  // Ready only for the granted source and only while the output register is
  // empty, so capture and drain can never coincide.
  always_comb begin
    s_axis_tready = '0;
    if (state == XFER) s_axis_tready[gidx] = ~vld_p0;
  end

  assign cap = (state == XFER) && s_axis_tvalid[gidx] && !vld_p0;
  assign drn = vld_p0 && m_axis_tready;

`ifdef SV_UART_ARB_PKT_LOCK_EN
  assign grant_end = (state == XFER) && drn && last_p0;
`else
  assign grant_end = (state == XFER) && drn;
`endif

  always_comb begin
    state_n   = state;
    gidx_n    = gidx;
    gap_cnt_n = gap_cnt;
    case (state)
      ARB: begin
        if (sel_found) begin
          state_n = XFER;
          gidx_n  = sel_idx;
        end
      end
      XFER: begin
        if (grant_end) begin
          if (igap != 16'd0) begin
            state_n   = GAP;
            gap_cnt_n = igap;
          end else begin
            state_n = ARB;
          end
        end
      end
      GAP: begin
        if (gap_cnt == 16'd1) begin
          state_n   = ARB;
          gap_cnt_n = 16'd0;
        end else begin
          gap_cnt_n = gap_cnt - 16'd1;
        end
      end
      default: state_n = ARB;
    endcase
    ogrant_n = '0;
    if (state_n == XFER) ogrant_n[gidx_n] = 1'b1;
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state      <= ARB;
      gidx       <= '0;
      last_grant <= ID_WIDTH'(NUM_SRC - 1);
      gap_cnt    <= '0;
      ogrant     <= '0;
      obusy      <= 1'b0;
    end else begin
      state   <= state_n;
      gidx    <= gidx_n;
      gap_cnt <= gap_cnt_n;
      ogrant  <= ogrant_n;
      obusy   <= (state_n != ARB);
      if (state == ARB && sel_found) last_grant <= sel_idx;
    end
  end

  // ---- stage p0: output register (reset clears it and drops any held word)
  always_ff @(posedge iclk) begin
    if (irst) begin
      vld_p0  <= 1'b0;
      data_p0 <= '0;
      tid_p0  <= '0;
`ifdef SV_UART_ARB_PKT_LOCK_EN
      last_p0 <= 1'b0;
`endif
    end else if (cap) begin
      vld_p0  <= 1'b1;
      data_p0 <= s_axis_tdata[int'(gidx)*DATA_WIDTH +: DATA_WIDTH];
      tid_p0  <= gidx;
`ifdef SV_UART_ARB_PKT_LOCK_EN
      last_p0 <= s_axis_tlast[gidx];
`endif
    end else if (drn) begin
      vld_p0  <= 1'b0;
    end
  end

  assign m_axis_tvalid = vld_p0;
  assign m_axis_tdata  = data_p0;
  assign m_axis_tid    = tid_p0;

endmodule

// File: tb/tb_sv_uart_tx_arbiter.sv
module tb_sv_uart_tx_arbiter;

  logic        iclk = 1'b0;
  logic        irst;
  logic [95:0] s_axis_tdata;
  logic [3:0]  s_axis_tvalid;
  logic [3:0]  s_axis_tlast;
  logic [3:0]  s_axis_tready;
  logic [23:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [1:0]  m_axis_tid;
  logic [15:0] igap;
  logic [3:0]  ogrant;
  logic        obusy;

  sv_uart_tx_arbiter #(.DATA_WIDTH(24), .NUM_SRC(4)) dut (
    .iclk(iclk), .irst(irst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tid(m_axis_tid),
    .igap(igap), .ogrant(ogrant), .obusy(obusy)
  );

  always #5 iclk = ~iclk;

  int n_vec  = 0;
  int n_fail = 0;

  // Source model: per-source word lists consumed on input handshakes.
  logic [23:0] src_data [4][8];
  logic        src_last [4][8];
  int          src_len  [4];
  int          src_ptr  [4];

  // Words seen leaving on the master side.
  logic [23:0] got_data  [16];
  logic [1:0]  got_tid   [16];
  logic [3:0]  got_grant [16];
  int          ngot;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic drive_srcs();
    for (int i = 0; i < 4; i++) begin
      if (src_ptr[i] < src_len[i]) begin
        s_axis_tvalid[i]          = 1'b1;
        s_axis_tdata[i*24 +: 24]  = src_data[i][src_ptr[i]];
        s_axis_tlast[i]           = src_last[i][src_ptr[i]];
      end else begin
        s_axis_tvalid[i]          = 1'b0;
        s_axis_tdata[i*24 +: 24]  = 24'h0;
        s_axis_tlast[i]           = 1'b0;
      end
    end
  endtask

  task automatic clear_srcs();
    for (int i = 0; i < 4; i++) begin
      src_len[i] = 0;
      src_ptr[i] = 0;
    end
    drive_srcs();
  endtask

  task automatic load_word(input int s, input int k, input logic [23:0] d, input logic l);
    src_data[s][k] = d;
    src_last[s][k] = l;
    if (src_len[s] < k + 1) src_len[s] = k + 1;
  endtask

  // One clock: note handshakes seen before the edge, then advance the model.
  task automatic cycle();
    logic [3:0] hs;
    hs = s_axis_tvalid & s_axis_tready;
    if (m_axis_tvalid && m_axis_tready && ngot < 16) begin
      got_data[ngot]  = m_axis_tdata;
      got_tid[ngot]   = m_axis_tid;
      got_grant[ngot] = ogrant;
      ngot++;
    end
    tick();
    for (int i = 0; i < 4; i++) if (hs[i]) src_ptr[i]++;
    drive_srcs();
  endtask

  task automatic collect(input int n, input int budget);
    int b;
    b = budget;
    while (ngot < n && b > 0) begin
      cycle();
      b--;
    end
    check("collect_done", 32'(ngot >= n), 32'd1);
  endtask

  task automatic do_reset();
    irst = 1'b1;
    clear_srcs();
    tick();
    tick();
    irst = 1'b0;
    ngot = 0;
  endtask

  initial begin : stim
    logic [1:0]  exp_tid3  [5];
    logic [23:0] exp_dat3  [5];
    int gap_busy, arb_idle, waitc;
    logic seen;

    irst = 1'b1; m_axis_tready = 1'b1; igap = 16'd0;
    s_axis_tdata = '0; s_axis_tvalid = '0; s_axis_tlast = '0;
    ngot = 0;

    // ---------------- reset values and single word from source 0
    do_reset();
    check("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_mdata",  32'(m_axis_tdata),  32'd0);
    check("rst_tid",    32'(m_axis_tid),    32'd0);
    check("rst_grant",  32'(ogrant),        32'd0);
    check("rst_busy",   32'(obusy),         32'd0);
    check("rst_sready", 32'(s_axis_tready), 32'd0);

    load_word(0, 0, 24'hA5A5A5, 1'b1);
    drive_srcs();
    check("w1_c0_mvalid", 32'(m_axis_tvalid), 32'd0);
    cycle();
    check("w1_c1_grant",  32'(ogrant),        32'h1);
    check("w1_c1_busy",   32'(obusy),         32'd1);
    check("w1_c1_sready", 32'(s_axis_tready), 32'h1);
    check("w1_c1_mvalid", 32'(m_axis_tvalid), 32'd0);
    cycle();
    check("w1_c2_mvalid", 32'(m_axis_tvalid), 32'd1);
    check("w1_c2_mdata",  32'(m_axis_tdata),  32'hA5A5A5);
    check("w1_c2_tid",    32'(m_axis_tid),    32'd0);
    check("w1_c2_sready", 32'(s_axis_tready), 32'd0);
    cycle();
    check("w1_c3_busy",   32'(obusy),         32'd0);
    check("w1_c3_grant",  32'(ogrant),        32'd0);
    check("w1_c3_mvalid", 32'(m_axis_tvalid), 32'd0);

    // ---------------- round robin, all four sources always valid
    do_reset();
    for (int s = 0; s < 4; s++)
      for (int k = 0; k < 8; k++)
        load_word(s, k, 24'(24'h100000 * (s + 1) + k), 1'b1);
    drive_srcs();
    collect(6, 60);
    for (int w = 0; w < 6; w++) begin
      check($sformatf("rr_tid%0d", w),   32'(got_tid[w]),   32'(w % 4));
      check($sformatf("rr_data%0d", w),  32'(got_data[w]),  32'(24'h100000 * ((w % 4) + 1) + (w / 4)));
      check($sformatf("rr_grant%0d", w), 32'(got_grant[w]), 32'(4'b0001 << (w % 4)));
    end

    // ---------------- 3-word packet on source 1 while source 2 is valid
    do_reset();
    load_word(1, 0, 24'h111001, 1'b0);
    load_word(1, 1, 24'h111002, 1'b0);
    load_word(1, 2, 24'h111003, 1'b1);
    for (int k = 0; k < 8; k++) load_word(2, k, 24'(24'h222000 + k), 1'b1);
    drive_srcs();
    collect(5, 60);
`ifdef SV_UART_ARB_PKT_LOCK_EN
    exp_tid3 = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2};
    exp_dat3 = '{24'h111001, 24'h111002, 24'h111003, 24'h222000, 24'h222001};
`else
    exp_tid3 = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd1};
    exp_dat3 = '{24'h111001, 24'h222000, 24'h111002, 24'h222001, 24'h111003};
`endif
    for (int w = 0; w < 5; w++) begin
      check($sformatf("pkt_tid%0d", w),  32'(got_tid[w]),  32'(exp_tid3[w]));
      check($sformatf("pkt_data%0d", w), 32'(got_data[w]), 32'(exp_dat3[w]));
    end

    // ---------------- idle gap of 5 between grants
    do_reset();
    igap = 16'd5;
    load_word(0, 0, 24'h0A0000, 1'b1);
    load_word(1, 0, 24'h0B0000, 1'b1);
    drive_srcs();
    collect(1, 20);
    igap = 16'd2;                   // changed mid-gap, must not matter
    gap_busy = 0; arb_idle = 0; seen = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (s_axis_tready[1]) begin
        seen = 1'b1;
        break;
      end
      if (obusy) gap_busy++;
      else       arb_idle++;
      cycle();
    end
    check("gap_seen_ready1", 32'(seen),     32'd1);
    check("gap_busy_cycles", 32'(gap_busy), 32'd5);
    check("gap_arb_cycles",  32'(arb_idle), 32'd1);
    collect(2, 20);
    check("gap_tid1", 32'(got_tid[1]),  32'd1);
    check("gap_data1", 32'(got_data[1]), 32'h0B0000);
    igap = 16'd0;

    // ---------------- back-pressure: output held for 10 cycles
    do_reset();
    m_axis_tready = 1'b0;
    load_word(2, 0, 24'hC3C3C3, 1'b1);
    load_word(3, 0, 24'h3D3D3D, 1'b1);
    drive_srcs();
    waitc = 0;
    while (!m_axis_tvalid && waitc < 10) begin
      cycle();
      waitc++;
    end
    check("bp_buffered", 32'(m_axis_tvalid), 32'd1);
    for (int t = 0; t < 10; t++) begin
      check($sformatf("bp_data%0d", t),   32'(m_axis_tdata),  32'hC3C3C3);
      check($sformatf("bp_tid%0d", t),    32'(m_axis_tid),    32'd2);
      check($sformatf("bp_sready%0d", t), 32'(s_axis_tready), 32'd0);
      cycle();
    end
    check("bp_still_valid", 32'(m_axis_tvalid), 32'd1);
    m_axis_tready = 1'b1;
    collect(2, 20);
    check("bp_next_tid",  32'(got_tid[1]),  32'd3);
    check("bp_next_data", 32'(got_data[1]), 32'h3D3D3D);

    // ---------------- reset with a buffered word
    do_reset();
    m_axis_tready = 1'b0;
    load_word(1, 0, 24'h5A5A5A, 1'b1);
    drive_srcs();
    waitc = 0;
    while (!m_axis_tvalid && waitc < 10) begin
      cycle();
      waitc++;
    end
    check("mr_buffered", 32'(m_axis_tvalid), 32'd1);
    irst = 1'b1;
    tick();
    check("mr_mvalid", 32'(m_axis_tvalid), 32'd0);
    check("mr_mdata",  32'(m_axis_tdata),  32'd0);
    check("mr_tid",    32'(m_axis_tid),    32'd0);
    check("mr_grant",  32'(ogrant),        32'd0);
    check("mr_busy",   32'(obusy),         32'd0);
    check("mr_sready", 32'(s_axis_tready), 32'd0);
    clear_srcs();
    for (int s = 0; s < 4; s++) load_word(s, 0, 24'(24'h700000 + s), 1'b1);
    drive_srcs();
    irst = 1'b0;
    ngot = 0;
    cycle();
    check("mr_first_grant", 32'(ogrant), 32'h1);
    m_axis_tready = 1'b1;
    collect(1, 20);
    check("mr_first_tid",  32'(got_tid[0]),  32'd0);
    check("mr_first_data", 32'(got_data[0]), 32'h700000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/sv_uart_tx_arbiter.md
# sv_uart_tx_arbiter

Round-robin arbiter that shares the single transmit channel of `sv_uart_engine` among `NUM_SRC` AXI-stream requesters. It sits between the requesters and the engine's `s_axis_*` port. Each grant is held for one word or for one whole packet, and the block can insert a programmable idle gap between grants. Output words are registered, and each carries the ID of its source.

## Interface
- `DATA_WIDTH`, default 24: word width. Must match the engine's `DATA_WIDTH`.
- `NUM_SRC`, default 4: number of requesters. Legal range is 2..16.
- `ID_WIDTH`, default `$clog2(NUM_SRC)`: width of the source ID.

Ports. One clock; reset is synchronous and active-high.
- `iclk`  in  1  clock
- `irst`  in  1  synchronous active-high reset
- `s_axis_tdata`  in  `NUM_SRC*DATA_WIDTH`  requester data. Source i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `s_axis_tvalid`  in  `NUM_SRC`  per-source valid
- `s_axis_tlast`  in  `NUM_SRC`  per-source end of packet
- `s_axis_tready`  out  `NUM_SRC`  per-source ready. At most one bit is high at any time.
- `m_axis_tdata`  out  `DATA_WIDTH`  data to the engine
- `m_axis_tvalid`  out  1  valid to the engine
- `m_axis_tready`  in  1  engine ready
- `m_axis_tid`  out  `ID_WIDTH`  source of the word currently in the output register
- `igap`  in  16  idle cycles inserted after each grant ends
- `ogrant`  out  `NUM_SRC`  one-hot current grant. All zero outside XFER.
- `obusy`  out  1  high in every state except ARB

## Operation
FSM states: ARB, XFER, GAP.

**ARB**
- If any `s_axis_tvalid` bit is high, select the first valid source searching upward from `last_grant+1`, wrapping modulo `NUM_SRC`.
- On the same edge: register the grant, update `last_grant`, and move to XFER.
- If no source is valid, stay in ARB.

**XFER**
- `s_axis_tready[g] = ~out_valid`, where g is the granted source. Every other ready bit is 0.
- Capture on `tvalid[g] & tready[g]`: load `m_axis_tdata`, set `m_axis_tid` to g, set `out_valid` to 1, and latch `tlast`.
- The output drains on `m_axis_tvalid & m_axis_tready`, which clears `out_valid`.
- The grant ends when the captured word drains and the grant-end condition holds (see Configuration). On grant end:
  - go to GAP if `igap != 0`, loading `gap_cnt` with `igap`;
  - otherwise go to ARB.
- If the source drops `tvalid` mid-packet, the grant is held indefinitely. There is no timeout.

**GAP**
- `gap_cnt` decrements once per cycle.
- Go to ARB on the cycle `gap_cnt == 1`, which gives exactly `igap` cycles in GAP.
- `igap` is sampled only on entry to GAP. Changes during GAP have no effect.

**Reset**
- All outputs go to 0.
- `last_grant` resets to `NUM_SRC-1`, so source 0 wins first.
- Reset mid-transfer discards the buffered word. The source is not informed.

**Rules**
- `m_axis_tdata`, `m_axis_tid` and `m_axis_tvalid` are stable while `m_axis_tvalid & ~m_axis_tready`.
- Sources that are not granted see `tready = 0`, even when they are valid.
- `tlast` on a source that is not granted is ignored.

## Timing
- Latency: requester valid in ARB, then grant on the next edge, then `tready[g]` high in the first XFER cycle. `m_axis_tvalid` rises 1 cycle after the capture handshake.
- Minimum of 2 cycles per word inside a grant, because the single output register has no bypass.
- Grant turnaround with `igap = 0` is 1 ARB cycle. With `igap = N` it is N GAP cycles plus 1 ARB cycle.
- `ogrant` and `obusy` are registered and change on the same edges as the state.
- Simultaneous events:
  - Drain and new capture cannot occur on the same cycle, since ready is `~out_valid`.
  - Grant end plus a new request: the new request is serviced only via ARB, never directly from XFER.

## Configuration
- Macro: `SV_UART_ARB_PKT_LOCK_EN`.
- **Defined:** the grant is held until the word captured with `tlast = 1` drains. Packets from different sources never interleave.
- **Undefined:** `s_axis_tlast` is ignored. The grant ends after every drained word, so the arbiter re-arbitrates word by word.

## Test plan
- Reset, then source 0 sends one word 0xA5A5A5 with `tlast` and `igap = 0`. Required: `m_axis_tdata = 0xA5A5A5`, `m_axis_tid = 0`, `tvalid` high 2 cycles after the source's first valid cycle, and the FSM back in ARB afterwards.
- All 4 sources continuously valid with single-word packets. Required: grant order 0, 1, 2, 3, 0, 1, and `m_axis_tid` follows the same sequence.
- With `PKT_LOCK_EN`: source 1 sends a 3-word packet while source 2 is valid. Required: 3 consecutive words with tid 1, then tid 2. Without the macro: tids alternate 1, 2, 1, 2, 1.
- `igap = 5`, sources 0 and 1 valid. Required: between the drain of source 0's word and source 1's `tready`, exactly 5 GAP cycles plus 1 ARB cycle, with `obusy` high during the gap.
- Hold `m_axis_tready` low for 10 cycles with a word buffered. Required: data and tid stable, and all `s_axis_tready` bits low.
- Assert `irst` during XFER with a word buffered. Required: all outputs 0 on the next cycle, and the first grant after reset goes to source 0.
